// File: rtl/gen_cla_pkg.sv
// Shared constants, term-layout helpers and FSM state type for the
// generated-carry linear adder.
package gen_cla_pkg;

    localparam int NBIT = 7;

    function automatic int nnl_width(input int nbit);
        return (2 ** (nbit + 2)) - nbit - 4;
    endfunction

    // Group j holds the ANF terms of carry c_(j+1); groups are packed back to back.
    function automatic int grp_base(input int j);
        return (2 ** (j + 2)) - 4 - j;
    endfunction

    function automatic int grp_size(input int j);
        return (2 ** (j + 2)) - 1;
    endfunction

    localparam int NNL = nnl_width(NBIT);
    localparam int GW  = grp_size(NBIT - 1);
    localparam int JW  = $clog2(NBIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

endpackage

// File: rtl/gen_linear_part_if.sv
// Operand/result handshake bundle for gen_linear_part.
interface gen_linear_part_if;
    import gen_cla_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [NNL-1:0]  n;
    logic [NBIT-1:0] a;
    logic [NBIT-1:0] b;
    logic            c;
    logic            out_valid;
    logic            out_ready;
    logic [NBIT-1:0] sum;
    logic            cout;
    logic            err;

    modport master (
        output in_valid, n, a, b, c, out_ready,
        input  in_ready, out_valid, sum, cout, err
    );

    modport slave (
        input  in_valid, n, a, b, c, out_ready,
        output in_ready, out_valid, sum, cout, err
    );

endinterface

// File: rtl/gen_group_xor.sv
// Selects term group sel from the packed term vector and XOR-reduces it;
// positions above the group's size are forced to zero.
module gen_group_xor
    import gen_cla_pkg::*;
(
    input  logic [NNL-1:0] n,
    input  logic [JW-1:0]  sel,
    output logic           par
);

    logic [GW-1:0] masked [NBIT];
    logic [GW-1:0] grp;

    for (genvar g = 0; g < NBIT; g++) begin : g_grp
        assign masked[g] = GW'(n[grp_base(g) +: grp_size(g)]);
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        grp = '0;
        if (sel < JW'(NBIT)) begin
            grp = masked[sel];
        end
        par = ^grp;
    end

endmodule

// File: rtl/gen_linear_part.sv
// Serial linear-part adder: one carry group per cycle from precomputed AND terms.
// Optional carry checker enabled by defining GEN_LIN_CHECK_EN.
module gen_linear_part
    import gen_cla_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    gen_linear_part_if.slave  bus
);

    state_t          state;
    state_t          state_nxt;
    logic [JW-1:0]   j;
    logic            last;
    logic            accept;
    logic            in_ready_c;
    logic            out_valid_c;

    logic [NNL-1:0]  n_q;
    logic [NBIT-1:0] a_q;
    logic [NBIT-1:0] b_q;
    logic            carry;
    logic            grp_par;

    logic [NBIT-1:0] sum_q;
    logic            cout_q;

    // The j==NBIT cycle only moves the final carry to cout, giving NBIT+1 ACC cycles.
    assign last   = (j == JW'(NBIT));
    assign accept = in_ready_c && bus.in_valid;

    gen_group_xor u_group_xor (
        .n   (n_q),
        .sel (j),
        .par (grp_par)
    );

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_nxt = ACC;
            end
            ACC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            j      <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                j <= '0;
            end else if (state == ACC) begin
                if (last) begin
                    cout_q <= carry;
                end else begin
                    sum_q[j] <= a_q[j] ^ b_q[j] ^ carry;
                    j        <= j + JW'(1);
                end
            end
        end
    end

    // NOTE: operand registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (accept) begin
            n_q   <= bus.n;
            a_q   <= bus.a;
            b_q   <= bus.b;
            carry <= bus.c;
        end else if (state == ACC && !last) begin
            carry <= grp_par;
        end
    end

`ifdef GEN_LIN_CHECK_EN
    logic maj;
    logic err_q;

    assign maj = (a_q[j] & b_q[j]) | (a_q[j] & carry) | (b_q[j] & carry);

    // Sticky per operation: any group whose parity disagrees with the true carry flags it.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (state == ACC && !last && (grp_par != maj)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

endmodule

// File: tb/tb_gen_linear_part.sv
// Directed self-checking bench for gen_linear_part; expected sums are hand-computed.
module tb_gen_linear_part;
    import gen_cla_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   acc_cnt  = 0;

`ifdef GEN_LIN_CHECK_EN
    localparam int EXP_CORRUPT_ERR = 1;
`else
    localparam int EXP_CORRUPT_ERR = 0;
`endif

    gen_linear_part_if bus();

    gen_linear_part dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Builds the ANF term vector: c_(j+1) = a_j b_j ^ a_j c_j ^ b_j c_j, expanded over c_j's terms.
    function automatic logic [NNL-1:0] gen_terms(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                                                 input logic c);
        logic [NNL-1:0] n;
        logic           prev [256];
        logic           cur  [256];
        int             cnt;
        n       = '0;
        prev[0] = c;
        cnt     = 1;
        for (int j = 0; j < NBIT; j++) begin
            cur[0] = a[j] & b[j];
            for (int k = 0; k < cnt; k++) begin
                cur[1 + k]       = a[j] & prev[k];
                cur[1 + cnt + k] = b[j] & prev[k];
            end
            cnt = 2 * cnt + 1;
            for (int k = 0; k < cnt; k++) n[grp_base(j) + k] = cur[k];
            prev = cur;
        end
        return n;
    endfunction

    task automatic start_op(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic c,
                            input logic [NNL-1:0] n);
        bus.a        = a;
        bus.b        = b;
        bus.c        = c;
        bus.n        = n;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [NBIT-1:0] a, input logic [NBIT-1:0] b,
                          input logic c, input logic [NNL-1:0] n,
                          input int exp_sum, input int exp_cout, input int exp_err);
        int lat;
        start_op(a, b, c, n);
        check({tag, "_busy"}, 32'(bus.in_ready), 0);
        wait_done(lat);
        check({tag, "_lat"}, lat, NBIT + 1);
        check({tag, "_sum"}, 32'(bus.sum), exp_sum);
        check({tag, "_cout"}, 32'(bus.cout), exp_cout);
        check({tag, "_err"}, 32'(bus.err), exp_err);
        step();
        check({tag, "_idle"}, 32'(bus.in_ready), 1);
    endtask

    initial begin
        logic [NNL-1:0] nv;
        int             lat;
        int             seen;
        int             cnt0;
        logic [NBIT-1:0] va [3];
        logic [NBIT-1:0] vb [3];
        logic            vc [3];
        int              vs [3];
        int              vo [3];

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.c = 1'b0; bus.n = '0;

        rst = 1'b1;
        step();
        step();
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_err", 32'(bus.err), 0);
        rst = 1'b0;
        step();

        run_op("basic", 7'h12, 7'h34, 1'b1, gen_terms(7'h12, 7'h34, 1'b1), 'h47, 0, 0);
        run_op("wrap", 7'h7F, 7'h01, 1'b0, gen_terms(7'h7F, 7'h01, 1'b0), 'h00, 1, 0);
        run_op("max", 7'h7F, 7'h7F, 1'b1, gen_terms(7'h7F, 7'h7F, 1'b1), 'h7F, 1, 0);
        run_op("zero", 7'h00, 7'h00, 1'b0, gen_terms(7'h00, 7'h00, 1'b0), 'h00, 0, 0);

        // Backpressure, with in_valid and different operands presented while busy.
        bus.out_ready = 1'b0;
        start_op(7'h35, 7'h4C, 1'b0, gen_terms(7'h35, 7'h4C, 1'b0));
        bus.a = 7'h11; bus.b = 7'h22; bus.c = 1'b1; bus.n = gen_terms(7'h11, 7'h22, 1'b1);
        bus.in_valid = 1'b1;
        wait_done(lat);
        check("bp_lat", lat, NBIT + 1);
        check("bp_sum", 32'(bus.sum), 'h01);
        check("bp_cout", 32'(bus.cout), 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", 32'(bus.out_valid), 1);
            check("bp_hold_ready", 32'(bus.in_ready), 0);
            check("bp_hold_sum", 32'(bus.sum), 'h01);
            check("bp_hold_cout", 32'(bus.cout), 1);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        step();
        check("bp_release_ready", 32'(bus.in_ready), 1);
        check("bp_release_valid", 32'(bus.out_valid), 0);

        // Corrupted term n[0] (a0&b0) breaks carry c_1.
        nv    = gen_terms(7'h01, 7'h01, 1'b0);
        nv[0] = 1'b0;
        run_op("corrupt", 7'h01, 7'h01, 1'b0, nv, 'h00, 0, EXP_CORRUPT_ERR);
        run_op("clean_after", 7'h12, 7'h34, 1'b1, gen_terms(7'h12, 7'h34, 1'b1), 'h47, 0, 0);

        // Reset during ACC cycle 3 discards the operation.
        start_op(7'h12, 7'h34, 1'b1, gen_terms(7'h12, 7'h34, 1'b1));
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_sum", 32'(bus.sum), 0);
        check("mid_rst_cout", 32'(bus.cout), 0);
        check("mid_rst_err", 32'(bus.err), 0);
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.out_valid === 1'b1) seen++;
        end
        check("mid_rst_no_output", seen, 0);

        // in_valid held high across three operations.
        va[0] = 7'h0A; vb[0] = 7'h05; vc[0] = 1'b0; vs[0] = 'h0F; vo[0] = 0;
        va[1] = 7'h40; vb[1] = 7'h40; vc[1] = 1'b1; vs[1] = 'h01; vo[1] = 1;
        va[2] = 7'h3C; vb[2] = 7'h0F; vc[2] = 1'b1; vs[2] = 'h4C; vo[2] = 0;
        cnt0 = acc_cnt;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a = va[k]; bus.b = vb[k]; bus.c = vc[k]; bus.n = gen_terms(va[k], vb[k], vc[k]);
            check("stream_idle", 32'(bus.in_ready), 1);
            step();
            check("stream_busy", 32'(bus.in_ready), 0);
            wait_done(lat);
            check("stream_lat", lat, NBIT + 1);
            check("stream_sum", 32'(bus.sum), vs[k]);
            check("stream_cout", 32'(bus.cout), vo[k]);
            if (k == 2) bus.in_valid = 1'b0;
            step();
        end
        step();
        check("stream_accepts", acc_cnt - cnt0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
